// File: rtl/fp32_pkg.sv
// Shared float32 field widths, constants and unpack helpers for the adder front end and normaliser.
// Latency: none (package only).
// Backpressure: not applicable.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int GRS_W  = 3;
  // carry + hidden + fraction + guard/round/sticky
  localparam int SUM_W  = FRAC_W + GRS_W + 2;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
  localparam int               BIAS        = 127;

  // IEEE-754 single split into its fields
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Stage-1 register contents: larger operand L, aligned smaller operand S
  typedef struct packed {
    logic              sign_l;
    logic              sign_s;
    logic [EXP_W-1:0]  exp_l;
    logic [SUM_W-1:0]  mant_l;
    logic [SUM_W-1:0]  mant_s;
    logic              special;
    logic              both_zero;
  } align_t;

  // Stage-2 register contents: unnormalised result
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [SUM_W-1:0]  mant;
    logic              special;
  } sum_t;

  // {carry=0, hidden, frac, GRS=0}; exponent 0 flushes to zero (no denormals)
  function automatic logic [SUM_W-1:0] unpack_mant(input fp32_t f);
    return (f.exp != '0) ? {1'b0, 1'b1, f.frac, {GRS_W{1'b0}}} : '0;
  endfunction

endpackage

// File: rtl/fp_sticky_rshift.sv
// Right barrel shift of a SUM_W-bit mantissa by d, ORing every bit shifted out into bit 0.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: din (mantissa in), d (shift distance, exponent width), dout (shifted mantissa with sticky).
module fp_sticky_rshift
  import fp32_pkg::*;
(
  input  logic [SUM_W-1:0] din,
  input  logic [EXP_W-1:0] d,
  output logic [SUM_W-1:0] dout
);

  logic [SUM_W-1:0] lost_mask;
  logic             sticky;

  always_comb begin
    lost_mask = '0;
    sticky    = 1'b0;
    dout      = '0;
    if (d >= EXP_W'(SUM_W)) begin
      // everything is shifted out; only the sticky survives
      dout[0] = |din;
    end else begin
      lost_mask = ~({SUM_W{1'b1}} << d);
      sticky    = |(din & lost_mask);
      dout      = din >> d;
      dout[0]   = dout[0] | sticky;
    end
  end

endmodule

// File: rtl/fp_align_add.sv
// Unpack two float32 operands, align the smaller to the larger exponent, add/subtract (unnormalised out).
// Latency: 2 cycles, throughput 1/cycle.
// Backpressure: out_ready low holds the output stage; in_ready drops only when both stages are full.
// Ports: clk/rst_n; in_valid/in_ready with a, b, op_sub (0 add, 1 A-B);
//        out_valid/out_ready with sign_out, exp_out, mant_out {carry,hidden,frac,G,R,S}, special (Inf/NaN seen).
module fp_align_add
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [SUM_W-1:0] mant_out,
  output logic             special
);

  fp32_t ua, ub;
  assign ua = a;
  assign ub = b;

  logic s1_valid, s2_valid;
  logic s1_load, s2_load;
  align_t s1_d, s1_q;
  sum_t   s2_d, s2_q;

  // Pipeline advance: a stage loads when it is empty or its contents move on this edge
  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // ---------------- Stage 1: unpack, order by magnitude, align ----------------
  logic             sign_b_eff;
  logic             swap;
  fp32_t            op_l, op_s;
  logic [EXP_W-1:0] shift_d;
  logic [SUM_W-1:0] mant_s_aligned;

  assign sign_b_eff = ub.sign ^ op_sub;
  // exponent:fraction compares as an unsigned magnitude; ties keep A as L
  assign swap       = {ub.exp, ub.frac} > {ua.exp, ua.frac};
  assign op_l       = swap ? ub : ua;
  assign op_s       = swap ? ua : ub;
  assign shift_d    = op_l.exp - op_s.exp;

  fp_sticky_rshift u_align (
    .din  (unpack_mant(op_s)),
    .d    (shift_d),
    .dout (mant_s_aligned)
  );

  always_comb begin
    s1_d           = '0;
    s1_d.sign_l    = swap ? sign_b_eff : ua.sign;
    s1_d.sign_s    = swap ? ua.sign : sign_b_eff;
    s1_d.exp_l     = op_l.exp;
    s1_d.mant_l    = unpack_mant(op_l);
    s1_d.mant_s    = mant_s_aligned;
    s1_d.special   = (ua.exp == EXP_SPECIAL) || (ub.exp == EXP_SPECIAL);
    s1_d.both_zero = (ua.exp == '0) && (ub.exp == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // ---------------- Stage 2: add / subtract ----------------
  logic [SUM_W-1:0] mant_sum;

  always_comb begin
    // L >= S by construction, so the difference never wraps
    mant_sum = (s1_q.sign_l == s1_q.sign_s) ? (s1_q.mant_l + s1_q.mant_s)
                                            : (s1_q.mant_l - s1_q.mant_s);
    s2_d         = '0;
    s2_d.special = s1_q.special;
    if (s1_q.special) begin
      // downstream builds the Inf/NaN encoding; only sign and exponent matter
      s2_d.sign = s1_q.sign_l;
      s2_d.exp  = EXP_SPECIAL;
    end else if (s1_q.both_zero) begin
      // signed-zero rule: only -0 + -0 stays negative
      s2_d.sign = s1_q.sign_l & s1_q.sign_s;
    end else if (mant_sum != '0) begin
      s2_d.sign = s1_q.sign_l;
      s2_d.exp  = s1_q.exp_l;
      s2_d.mant = mant_sum;
    end
    // exact cancellation leaves the all-zero default (+0)
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  assign out_valid = s2_valid;
  assign sign_out  = s2_q.sign;
  assign exp_out   = s2_q.exp;
  assign mant_out  = s2_q.mant;
  assign special   = s2_q.special;

endmodule

// File: tb/tb_fp_align_add.sv
// Directed bench for fp_align_add with a scoreboard queue of expected results.
// Latency: checks 2-cycle latency and stall/reset behaviour.
// Backpressure: drives out_ready low to fill both stages.
module tb_fp_align_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [27:0] mant_out;
  logic        special;

  fp_align_add dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .mant_out  (mant_out),
    .special   (special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] E1 = 8'(fp32_pkg::BIAS);

  logic [37:0] res;
  assign res = {special, sign_out, exp_out, mant_out};

  logic [37:0] sb[$];
  string       tq[$];
  logic [37:0] cur_exp;
  string       cur_tag;
  logic        acc;
  int          checks;
  int          errors;

  function automatic logic [37:0] mk(input logic sp, input logic sg,
                                     input logic [7:0] ex, input logic [27:0] mt);
    return {sp, sg, ex, mt};
  endfunction

  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: record input/output handshakes at the negedge, return just after the posedge
  task automatic step();
    logic [37:0] e;
    string       t;
    @(negedge clk);
    if (in_valid && in_ready) begin
      sb.push_back(cur_exp);
      tq.push_back(cur_tag);
      acc = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {37'b0, out_valid}, 38'd0);
      end else begin
        e = sb.pop_front();
        t = tq.pop_front();
        check(t, res, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                      input logic top, input logic [37:0] e);
    a        = ta;
    b        = tbv;
    op_sub   = top;
    cur_exp  = e;
    cur_tag  = tag;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step();
    if (!acc) check({tag, "_accept_timeout"}, {37'b0, acc}, 38'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    check({tag, "_drain"}, 38'(sb.size()), 38'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    acc       = 1'b0;
    cur_exp   = '0;
    cur_tag   = "";
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {37'b0, out_valid}, 38'd0);
    check("reset_fields", res, 38'd0);
    check("reset_in_ready", {37'b0, in_ready}, 38'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // 1.0 + 1.0 with latency check
    send("add_1p1", 32'h3F800000, 32'h3F800000, 1'b0, mk(0, 0, E1, 28'h8000000));
    check("lat_cycle1", {37'b0, out_valid}, 38'd0);
    step();
    check("lat_cycle2", {37'b0, out_valid}, 38'd1);
    drain("t1");

    // directed arithmetic, back to back
    send("sub_1p5_1",   32'h3FC00000, 32'h3F800000, 1'b1, mk(0, 0, E1,    28'h2000000));
    send("sub_cancel",  32'h3F800000, 32'h3F800000, 1'b1, mk(0, 0, 8'h00, 28'h0000000));
    send("add_tiny",    32'h3F800000, 32'h30800000, 1'b0, mk(0, 0, E1,    28'h4000001));
    send("sub_2_1",     32'h40000000, 32'h3F800000, 1'b1, mk(0, 0, 8'h80, 28'h2000000));
    send("add_d27",     32'h3F800000, 32'h32000000, 1'b0, mk(0, 0, E1,    28'h4000001));
    send("add_d4_stky", 32'h3F800000, 32'h3D800001, 1'b0, mk(0, 0, E1,    28'h4400001));
    send("sub_tiny",    32'h3F800000, 32'h30800000, 1'b1, mk(0, 0, E1,    28'h3FFFFFF));
    send("sub_neg",     32'h3F800000, 32'h40000000, 1'b1, mk(0, 1, 8'h80, 28'h2000000));
    send("add_opp_eq",  32'hBFC00000, 32'h3FC00000, 1'b0, mk(0, 0, 8'h00, 28'h0000000));
    send("negz_sub_z",  32'h80000000, 32'h00000000, 1'b1, mk(0, 1, 8'h00, 28'h0000000));
    send("z_add_negz",  32'h00000000, 32'h80000000, 1'b0, mk(0, 0, 8'h00, 28'h0000000));
    send("denorm_flush",32'h3F800000, 32'h00000001, 1'b0, mk(0, 0, E1,    28'h4000000));
    send("add_carry",   32'h3FC00000, 32'h3FC00000, 1'b0, mk(0, 0, E1,    28'hC000000));
    send("inf_add",     32'h7F800000, 32'h3F800000, 1'b0, mk(1, 0, 8'hFF, 28'h0000000));
    send("neginf_add",  32'hFF800000, 32'h3F800000, 1'b0, mk(1, 1, 8'hFF, 28'h0000000));
    send("sub_inf",     32'h3F800000, 32'h7F800000, 1'b1, mk(1, 1, 8'hFF, 28'h0000000));
    drain("directed");

    // stall: fill both stages with out_ready low
    out_ready = 1'b0;
    send("stream0", 32'h3F800000, 32'h3F800000, 1'b0, mk(0, 0, E1,    28'h8000000));
    send("stream1", 32'h3FC00000, 32'h3F800000, 1'b1, mk(0, 0, E1,    28'h2000000));
    check("stall_in_ready", {37'b0, in_ready}, 38'd0);
    check("stall_out_valid", {37'b0, out_valid}, 38'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", res, mk(0, 0, E1, 28'h8000000));
      check("stall_in_ready_hold", {37'b0, in_ready}, 38'd0);
    end
    out_ready = 1'b1;
    send("stream2", 32'h40000000, 32'h3F800000, 1'b1, mk(0, 0, 8'h80, 28'h2000000));
    send("stream3", 32'h3F800000, 32'h30800000, 1'b0, mk(0, 0, E1,    28'h4000001));
    drain("stream");
    for (int i = 0; i < 3; i++) step();
    check("stream_no_dup", {37'b0, out_valid}, 38'd0);

    // reset with two items in flight
    out_ready = 1'b0;
    send("flight0", 32'h3F800000, 32'h3F800000, 1'b0, mk(0, 0, E1, 28'h8000000));
    send("flight1", 32'h3FC00000, 32'h3F800000, 1'b1, mk(0, 0, E1, 28'h2000000));
    check("flight_out_valid", {37'b0, out_valid}, 38'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {37'b0, out_valid}, 38'd0);
    check("midrst_fields", res, 38'd0);
    check("midrst_in_ready", {37'b0, in_ready}, 38'd1);
    sb.delete();
    tq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_in_ready", {37'b0, in_ready}, 38'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("postrst_no_stale", {37'b0, out_valid}, 38'd0);
    end

    // pipeline still works after reset
    send("post_rst_add", 32'h3F800000, 32'h3F800000, 1'b0, mk(0, 0, E1, 28'h8000000));
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
